clk_prescale_prog: RTL
======================

// Module: clk_prescale_prog
// PURPOSE
//  Runtime-programmable clock prescaler. Divides clk by 2*(H+1), where H is a
//  half-period count loaded through a load/ack handshake. New divisors are
//  applied only at period boundaries, so clk_out never glitches. Enable
//  start/stop is glitch-free. Single-cycle rise/fall strobes are provided so
//  downstream logic can stay on clk instead of clocking from clk_out.
//  Sits between the master-clock input and the codec/serial-timing blocks.
// PARAMETERS
//  CNT_W        8   width of the half-period counter and of half_period
//  DEFAULT_HALF 9   H loaded at reset (49.152MHz/(2*10) = 2.4576MHz)
// PORTS
//  clk          in   1      master clock; all logic is on the posedge
//  reset_n      in   1      asynchronous reset, active low
//  enable       in   1      run request; level-sensitive
//  half_period  in   CNT_W  new H value; sampled only when load=1
//  load         in   1      1-cycle request to load half_period
//  load_ack     out  1      1-cycle pulse when a loaded H becomes active
//  clk_out      out  1      divided clock, 50% duty, registered
//  rise_stb     out  1      high for the clk cycle in which clk_out goes 0->1
//  fall_stb     out  1      high for the clk cycle in which clk_out goes 1->0
//  active       out  1      1 while the divider is running
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - cnt=0, clk_out=0, h_cur=DEFAULT_HALF, pend_vld=0.
//   - load_ack, rise_stb, fall_stb and active are all 0.
//  Period definition: a low phase of h_cur+1 clks, then a high phase of
//   h_cur+1 clks. A period ends at the 1->0 toggle. H=0 gives clk/2.
//  Running (active=1), each posedge:
//   - If cnt!=h_cur: cnt<=cnt+1.
//   - Else: cnt<=0 and clk_out<=~clk_out. Assert rise_stb or fall_stb in the
//     same registered cycle that clk_out changes.
//  Divisor update:
//   - load=1 captures half_period into pend and sets pend_vld=1.
//   - While running, pend is applied only on the 1->0 toggle:
//     h_cur<=pend, pend_vld<=0, load_ack=1 for one cycle.
//   - While stopped, pend is applied on the cycle after the load, with
//     load_ack pulsed.
//   - A second load before apply overwrites pend. The last value wins and only
//     one ack is issued.
//   - If a load coincides with an apply, the old pend is applied and acked.
//     The new value becomes pend_vld=1 and is applied at the next boundary.
//   - h_cur never changes mid-period, so cnt<=h_cur always holds.
//  Enable/stop:
//   - Start: active rises one clk after enable=1 is sampled while stopped.
//     The first rise_stb occurs h_cur+1 clks later.
//   - enable=0 sampled in the low phase: stop immediately. cnt<=0, clk_out
//     stays 0, active<=0, and no strobe is issued.
//   - enable=0 sampled in the high phase: finish the high phase, then do the
//     1->0 toggle with fall_stb. Any pending apply happens on that toggle.
//     Then cnt<=0 and active<=0.
//   - enable re-asserted during a high-phase drain: the drain completes and
//     the divider restarts on the next cycle. The restart is a fresh low
//     phase with cnt=0.
//  Width rules:
//   - cnt is CNT_W bits unsigned. H=2^CNT_W-1 is legal (max divide
//     2^(CNT_W+1)).
//   - cnt never wraps, because the compare terminates at h_cur.
// TESTING
//  1 Reset, enable=1, H=9: clk_out period is 20 clks with 10 high. The first
//    rise_stb comes 10 clks after active=1.
//  2 Running at H=9, load H=1 mid-high-phase: H=9 holds until the next fall.
//    load_ack pulses with fall_stb, and the period is then 4 clks.
//  3 Two loads (H=3, then H=5) before a boundary: a single load_ack is
//    issued, after which the period is 12.
//  4 Deassert enable at cnt=4 of the low phase: clk_out stays 0, no strobes,
//    active=0 next clk.
//  5 Deassert enable in the high phase with H=7: clk_out stays high for 8
//    clks, then falls with fall_stb, then active=0.
//  6 H=0: clk_out toggles every clk. Assert reset_n=0 mid-period: clk_out=0
//    at once, and h_cur returns to DEFAULT_HALF.

Source files
------------

// File: rtl/clk_prescale_prog_if.sv
// -----------------------------------------------------------------------------
// clk_prescale_prog_if
// Groups the control and status signals of the programmable clock prescaler.
//   enable       master -> slave  run request, level-sensitive
//   half_period  master -> slave  new half-period count H (CNT_W bits)
//   load         master -> slave  1-cycle request to capture half_period
//   load_ack     slave -> master  1-cycle pulse when a loaded H becomes active
//   clk_out      slave -> master  divided clock, 50% duty, registered
//   rise_stb     slave -> master  high in the cycle clk_out goes 0->1
//   fall_stb     slave -> master  high in the cycle clk_out goes 1->0
//   active       slave -> master  1 while the divider is running
// -----------------------------------------------------------------------------
interface clk_prescale_prog_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic [CNT_W-1:0] half_period;
    logic             load;
    logic             load_ack;
    logic             clk_out;
    logic             rise_stb;
    logic             fall_stb;
    logic             active;

    modport master (
        output enable, half_period, load,
        input  load_ack, clk_out, rise_stb, fall_stb, active
    );

    modport slave (
        input  enable, half_period, load,
        output load_ack, clk_out, rise_stb, fall_stb, active
    );
endinterface

// File: rtl/clk_prescale_prog.sv
// -----------------------------------------------------------------------------
// clk_prescale_prog
// Runtime-programmable clock prescaler: divides clk by 2*(H+1). A period is a
// low phase of H+1 clks followed by a high phase of H+1 clks and ends at the
// 1->0 toggle. New H values are only applied at that boundary (or right away
// while stopped), so clk_out never glitches. Rise/fall strobes let downstream
// logic stay on clk.
// Ports:
//   clk      master clock, all logic on posedge
//   reset_n  asynchronous reset, active low
//   bus      clk_prescale_prog_if.slave (enable, half_period, load in;
//            load_ack, clk_out, rise_stb, fall_stb, active out)
// -----------------------------------------------------------------------------
module clk_prescale_prog #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    clk_prescale_prog_if.slave bus
);

    // IDLE: stopped. RUN: counting normally. DRAIN: enable dropped during the
    // high phase; finish that phase, do the falling toggle, then stop.
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] h_cur_q, h_cur_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             ack_q, ack_d;

    logic terminal;
    logic toggle;
    logic apply;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d    = state_q;
        cnt_d      = cnt_q;
        h_cur_d    = h_cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clk_out_d  = clk_out_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        ack_d      = 1'b0;
        toggle     = 1'b0;
        apply      = 1'b0;
        terminal   = (cnt_q == h_cur_q);

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                // While stopped a pending H takes effect one cycle after load.
                apply     = pend_vld_q;
                if (bus.enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!clk_out_q && !bus.enable) begin
                    // Stop in the low phase: clk_out is already 0, no strobe.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (clk_out_q && !bus.enable) state_d = ST_DRAIN;
                    if (terminal) toggle = 1'b1;
                    else          cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                // Enable is ignored here; the drain always completes.
                if (terminal) toggle = 1'b1;
                else          cnt_d  = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (toggle) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            rise_d    = ~clk_out_q;
            fall_d    = clk_out_q;
            if (clk_out_q) begin
                // Period boundary: the only point where a running divider may
                // change H, and the point where a drain finally stops.
                apply = pend_vld_q;
                if (state_d == ST_DRAIN) state_d = ST_IDLE;
            end
        end

        // Apply first, then capture: a load coinciding with an apply leaves
        // the new value pending for the next boundary.
        if (apply) begin
            h_cur_d    = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
        end
        if (bus.load) begin
            pend_d     = bus.half_period;
            pend_vld_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order. All registers
    // are reset, including pend_q, so the block comes up fully deterministic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            h_cur_q    <= CNT_W'(DEFAULT_HALF);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            h_cur_q    <= h_cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.clk_out  = clk_out_q;
    assign bus.rise_stb = rise_q;
    assign bus.fall_stb = fall_q;
    assign bus.load_ack = ack_q;
    assign bus.active   = (state_q != ST_IDLE);

endmodule
